// File: rtl/seq_shifter_pkg.sv
// Shared constants for the multi-cycle shifter: mode codes and FSM state encoding.
package seq_shifter_pkg;

    localparam logic [2:0] SH_PASS = 3'b000;
    localparam logic [2:0] SH_LSL  = 3'b001;
    localparam logic [2:0] SH_LSR  = 3'b010;
    localparam logic [2:0] SH_ASR  = 3'b011;
    localparam logic [2:0] SH_ROL  = 3'b100;
    localparam logic [2:0] SH_ROR  = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Codes 110/111 fall through to pass, so only LSL..ROR need the SHIFT state.
    function automatic logic is_shift_mode(input logic [2:0] m);
        return (m >= SH_LSL) && (m <= SH_ROR);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves a WIDTH-bit value by 0..STEP positions.
module shift_step
    import seq_shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    parameter int SW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic [2:0]       mode_i,
    input  logic [SW-1:0]    n_i,
    input  logic             fill_i,
    output logic [WIDTH-1:0] res_o
);

    logic [2*WIDTH-1:0] dbl_l;
    logic [2*WIDTH-1:0] dbl_r;
    logic [WIDTH-1:0]   fill_mask;

    // Rotates come from shifting a doubled copy and taking the wrapped half.
    assign dbl_l     = {val_i, val_i} << n_i;
    assign dbl_r     = {val_i, val_i} >> n_i;
    assign fill_mask = ~({WIDTH{1'b1}} >> n_i);

    always_comb begin
        res_o = val_i;
        case (mode_i)
            SH_LSL:  res_o = val_i << n_i;
            SH_LSR:  res_o = val_i >> n_i;
            SH_ASR:  res_o = (val_i >> n_i) | (fill_i ? fill_mask : '0);
            SH_ROL:  res_o = dbl_l[2*WIDTH-1:WIDTH];
            SH_ROR:  res_o = dbl_r[WIDTH-1:0];
            default: res_o = val_i;
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter with valid/ready handshake; shifts up to STEP positions per clock.
module seq_shifter
    import seq_shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             busy
);

    localparam int SW = $clog2(STEP + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [AMT_W-1:0] count_q, count_d;
    logic [2:0]       mode_q, mode_d;
    logic             fill_q, fill_d;
    logic [SW-1:0]    step_n;
    logic [WIDTH-1:0] step_res;

    // Final step takes only what is left of the count.
    assign step_n = (int'(count_q) < STEP) ? SW'(count_q) : SW'(STEP);

    shift_step #(.WIDTH(WIDTH), .STEP(STEP), .SW(SW)) u_step (
        .val_i  (work_q),
        .mode_i (mode_q),
        .n_i    (step_n),
        .fill_i (fill_q),
        .res_o  (step_res)
    );

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        dout_d  = dout_q;
        count_d = count_q;
        mode_d  = mode_q;
        fill_d  = fill_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = din;
                    mode_d  = mode;
                    fill_d  = din[WIDTH-1];
                    count_d = amt;
                    if (amt == '0 || !is_shift_mode(mode)) begin
                        dout_d  = din;
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_d  = step_res;
                count_d = count_q - AMT_W'(step_n);
                if (count_q == AMT_W'(step_n)) begin
                    dout_d  = step_res;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            work_q  <= '0;
            dout_q  <= '0;
            count_q <= '0;
            mode_q  <= SH_PASS;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            dout_q  <= dout_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            fill_q  <= fill_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign dout      = dout_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench: three shifter instances (STEP=1,2,4) driven in lockstep, checked against hand values.
module tb_seq_shifter;
    import seq_shifter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] din;
    logic [2:0]  mode;
    logic [3:0]  amt;
    logic        out_ready;
    logic [2:0]  ir, ov, bz;
    logic [15:0] dq [3];

    int n_cmp = 0;
    int n_err = 0;
    int steps [3] = '{1, 2, 4};

    always #5 clk = ~clk;

    seq_shifter #(.WIDTH(16), .STEP(1)) u_s1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]), .din(din),
        .mode(mode), .amt(amt), .out_valid(ov[0]), .out_ready(out_ready), .dout(dq[0]), .busy(bz[0]));
    seq_shifter #(.WIDTH(16), .STEP(2)) u_s2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]), .din(din),
        .mode(mode), .amt(amt), .out_valid(ov[1]), .out_ready(out_ready), .dout(dq[1]), .busy(bz[1]));
    seq_shifter #(.WIDTH(16), .STEP(4)) u_s4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[2]), .din(din),
        .mode(mode), .amt(amt), .out_valid(ov[2]), .out_ready(out_ready), .dout(dq[2]), .busy(bz[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic [2:0] m, input logic [3:0] a, input int s);
        if (!is_shift_mode(m) || a == 4'd0) return 0;
        return (int'(a) + s - 1) / s;
    endfunction

    task automatic scramble();
        din  = 16'($urandom);
        mode = 3'($urandom_range(0, 7));
        amt  = 4'($urandom);
    endtask

    // Issue one request, scramble inputs while it runs, measure latency and result per instance.
    task automatic run(input string tag, input logic [15:0] d, input logic [2:0] m,
                       input logic [3:0] a, input logic [15:0] exp);
        int          lat [3];
        logic [15:0] res [3];
        @(negedge clk);
        in_valid = 1'b1; din = d; mode = m; amt = a; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin lat[i] = -1; res[i] = '0; end
        for (int c = 0; c < 20; c++) begin
            for (int i = 0; i < 3; i++)
                if (lat[i] < 0 && ov[i]) begin lat[i] = c; res[i] = dq[i]; end
            scramble();
            @(posedge clk); #1;
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s lat S%0d", tag, steps[i]), 32'(lat[i]), 32'(exp_lat(m, a, steps[i])));
            chk($sformatf("%s dout S%0d", tag, steps[i]), 32'(res[i]), 32'(exp));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, " back to idle"}, 32'(ir), 32'h7);
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; din = '0; mode = '0; amt = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", 32'(ir), 32'h7);
        chk("reset out_valid", 32'(ov), 32'h0);
        chk("reset busy", 32'(bz), 32'h0);
        chk("reset dout", 32'(dq[0]), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        run("lsl1",  16'hF0CF, SH_LSL,  4'd1,  16'hE19E);
        run("lsr1",  16'hF0CF, SH_LSR,  4'd1,  16'h7867);
        run("asr1",  16'hF0CF, SH_ASR,  4'd1,  16'hF867);
        run("pass1", 16'hF0CF, SH_PASS, 4'd1,  16'hF0CF);
        run("ror4",  16'hF0CF, SH_ROR,  4'd4,  16'hFF0C);
        run("rol4",  16'hF0CF, SH_ROL,  4'd4,  16'h0CFF);
        run("lsl15", 16'hF0CF, SH_LSL,  4'd15, 16'h8000);
        run("asr15", 16'hF0CF, SH_ASR,  4'd15, 16'hFFFF);
        run("lsr15", 16'hF0CF, SH_LSR,  4'd15, 16'h0001);
        run("rol15", 16'hF0CF, SH_ROL,  4'd15, 16'hF867);
        run("ror15", 16'hF0CF, SH_ROR,  4'd15, 16'hE19F);
        run("m110",  16'hF0CF, 3'b110,  4'd5,  16'hF0CF);
        run("asr3p", 16'h1234, SH_ASR,  4'd3,  16'h0246);
        run("lsl0",  16'hF0CF, SH_LSL,  4'd0,  16'hF0CF);

        // Backpressure: result held, new request ignored while DONE.
        @(negedge clk);
        in_valid = 1'b1; din = 16'hF0CF; mode = SH_LSL; amt = 4'd1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("bp done", 32'(ov), 32'h7);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; din = 16'h1234; mode = SH_LSR; amt = 4'd2;
            @(posedge clk); #1;
            chk("bp dout", 32'(dq[0]), 32'hE19E);
            chk("bp in_ready", 32'(ir), 32'h0);
            chk("bp busy", 32'(bz), 32'h7);
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp release in_ready", 32'(ir), 32'h7);
        chk("bp release out_valid", 32'(ov), 32'h0);
        chk("bp dout kept", 32'(dq[0]), 32'hE19E);
        out_ready = 1'b0;

        // Async reset in the middle of a long shift.
        @(negedge clk);
        in_valid = 1'b1; din = 16'hF0CF; mode = SH_ROL; amt = 4'd10;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("pre-reset busy S1", 32'(bz[0]), 32'h1);
        reset = 1'b1;
        #1;
        chk("midreset out_valid", 32'(ov), 32'h0);
        chk("midreset busy", 32'(bz), 32'h0);
        chk("midreset in_ready", 32'(ir), 32'h7);
        chk("midreset dout S1", 32'(dq[0]), 32'h0);
        chk("midreset dout S4", 32'(dq[2]), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        run("post-reset ror4", 16'hF0CF, SH_ROR, 4'd4, 16'hFF0C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
Parametrised multi-cycle shifter, successor to the datapath's fixed 16-bit, single-position shifter. Shifts a WIDTH-bit operand by a run-time amount in one of six modes, consuming STEP bit positions per clock. Uses a valid/ready handshake on input and output, so the controller can issue a shift and stall until the result returns. Sits between the register file read port and the ALU B input in the next datapath revision.

Parameters:
WIDTH, 16, operand width; power of two, at least 4.
STEP, 1, maximum positions shifted per cycle; power of two, at most WIDTH.
AMT_W, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  request present.
in_ready  output  1  block can accept a request (high only in IDLE).
din  input  WIDTH  operand.
mode  input  3  shift mode (see Behaviour).
amt  input  AMT_W  shift amount, 0..WIDTH-1.
out_valid  output  1  result available.
out_ready  input  1  consumer takes result.
dout  output  WIDTH  result.
busy  output  1  high in SHIFT or DONE.

Behaviour:
- Modes: 000 pass; 001 LSL; 010 LSR (zero fill); 011 ASR (sign fill from the operand MSB latched at accept); 100 ROL; 101 ROR; 110 and 111 behave as pass.
- Reset (async, any state, including mid-shift): state=IDLE, internal count=0, dout=0, out_valid=0, busy=0, in_ready=1. Any in-flight operation is discarded.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready at an edge, latch din, mode and amt. If amt==0, or mode is pass/110/111, go to DONE with dout=din. Otherwise go to SHIFT with count=amt.
  - SHIFT: each edge shifts the working register by s=min(STEP,count) and sets count-=s. When count reaches 0, go to DONE.
  - DONE: out_valid=1 and dout is held stable. On out_valid&&out_ready, go to IDLE. The block does not accept a new request in the same cycle.
- Latency: out_valid rises N=ceil(amt/STEP) edges after the accept edge; N=0 means it rises on the accept edge itself. With STEP=1 and amt=4, that is 4 edges.
- dout is valid only while out_valid=1. After the result is taken it keeps its last value until the next result loads.
- din, mode and amt are ignored outside the accept edge, so changes during SHIFT have no effect.
- Backpressure: out_ready low holds DONE indefinitely with dout unchanged.
- Final result must equal the single-step shift applied amt times. For rotates this is rotation modulo WIDTH.

Decomposition:
- Shared package seq_shifter_pkg holds:
  - mode constants: SH_PASS, SH_LSL, SH_LSR, SH_ASR, SH_ROL, SH_ROR;
  - state encoding: IDLE, SHIFT, DONE (2 bits).
- One combinational sub-module, shift_step: shifts a WIDTH-bit value by 0..STEP positions for a given mode, with the ASR fill bit as an explicit input. The FSM, counter and handshake live in seq_shifter.

Test Plan:
- WIDTH=16, STEP=1, din=16'hF0CF, amt=1: modes LSL/LSR/ASR/pass -> dout 16'hE19E/16'h7867/16'hF867/16'hF0CF. out_valid rises 1 edge after accept (0 edges for pass).
- din=16'hF0CF, amt=4: ROR -> 16'hFF0C, ROL -> 16'h0CFF. out_valid rises 4 edges after accept with STEP=1, and 1 edge after with STEP=4.
- din=16'hF0CF, amt=15: LSL -> 16'h8000, ASR -> 16'hFFFF, LSR -> 16'h0001. Repeat with STEP=2, where out_valid rises 8 edges after accept.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> dout stable and in_ready=0 throughout; a new in_valid during that time is not accepted. Raising out_ready returns the block to IDLE the next edge.
- Reset asserted mid-SHIFT (amt=10, after 3 edges) -> out_valid, busy and dout go to 0 immediately (async) and in_ready goes to 1. A fresh request after reset deasserts completes correctly.
- Change din, mode and amt on every cycle during SHIFT -> result matches the values latched at accept.
